seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring divider (radix-2, one quotient bit per cycle) for DIV/DIVU in the multi-cycle MIPS core.
//  Complements the Booth multiplier in the HI/LO unit: the main control FSM pulses start,
//  stalls while busy, then captures quotient (LO) and remainder (HI) on valid.
//  Single module: internal FSM plus datapath (partial remainder, quotient shift reg, iteration counter).
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
// PORTS
//  CLK          in   1      clock; all state changes on rising edge
//  RST          in   1      reset; asynchronous, active-low
//  start        in   1      request; sampled only in IDLE
//  is_signed    in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start
//  dividend     in   WIDTH  sampled with start
//  divisor      in   WIDTH  sampled with start
//  quotient     out  WIDTH  result, registered, held until next FIX
//  remainder    out  WIDTH  result, registered, held until next FIX
//  div_by_zero  out  1      flag for last result, held with results
//  busy         out  1      high from cycle after start accepted through the valid cycle
//  valid        out  1      one-cycle pulse: results updated this cycle
// BEHAVIOUR
//  Reset: state=IDLE; quotient, remainder, div_by_zero, busy, valid, counter, internal regs = 0.
//  Reset mid-operation aborts immediately; no valid issued; outputs return to 0.
//  States: IDLE, INIT, ITER, FIX.
//  IDLE: start=1 at edge -> latch operands and is_signed, go INIT. start=0 -> stay IDLE.
//  INIT: neg_q = is_signed & (dividend[MSB]^divisor[MSB]); neg_r = is_signed & dividend[MSB].
//   Load |dividend|, |divisor| (abs only when is_signed; |-2^(W-1)| = 2^(W-1) as unsigned).
//   Partial remainder = 0, count = 0. divisor==0 -> FIX (zero path); else -> ITER.
//  ITER (exactly WIDTH cycles): {R,Q} shifted left 1; trial = R' - D (WIDTH+1 bits);
//   trial >= 0 -> R = trial, Q[0]=1; else R unchanged, Q[0]=0. count++; count==WIDTH-1 -> FIX.
//  FIX (1 cycle): quotient = neg_q ? -Q : Q; remainder = neg_r ? -R : R; valid=1; -> IDLE.
//   Zero path: quotient = all ones, remainder = original dividend, div_by_zero=1.
//   Otherwise div_by_zero=0.
//  Latency (start sampled at edge 0): valid high after edge WIDTH+2 (normal), after edge 2 (divisor 0).
//  busy: high in INIT, ITER, FIX states. valid and busy both high in the FIX cycle.
//  start while busy ignored (not queued). start in the valid cycle ignored (FIX, not IDLE).
//  Back-to-back: start asserted in first IDLE cycle after valid is accepted.
//  Sign rules: quotient truncates toward zero; nonzero remainder takes dividend's sign.
//  Overflow: signed -2^(W-1) / -1 -> quotient = -2^(W-1), remainder = 0, no flag.
//  All arithmetic modulo 2^WIDTH; internal subtract WIDTH+1 bits to avoid carry loss.
// TESTING (WIDTH=32)
//  DIVU 100/7, start at edge 0 -> valid pulse after edge 34 only; q=14, r=2, dbz=0; busy high 34 cycles.
//  DIV -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; DIV 7/-2 -> q=0xFFFFFFFD, r=1;
//   DIVU 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
//  DIV 5/0 -> valid after edge 2; q=0xFFFFFFFF, r=5, dbz=1; next DIVU 9/3 -> dbz=0, q=3, r=0.
//  DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; DIVU same operands -> q=0, r=0x80000000.
//  Start pulses during busy with different operands -> ignored; exactly one valid, original result.
//  RST low at iteration 10 -> all outputs 0 immediately; no valid; fresh start gives correct result.

Source files
------------

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
// Latency: valid is high in the FIX cycle, WIDTH+2 cycles after start (2 cycles for a zero divisor).
// No backpressure: start is ignored while busy, and the results are held until the next FIX.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sgn;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic             last_iter;

    always_comb begin
        a_neg     = op_sgn & op_a[WIDTH-1];
        b_neg     = op_sgn & op_b[WIDTH-1];
        a_abs     = a_neg ? -op_a : op_a;
        b_abs     = b_neg ? -op_b : op_b;
        // The shifted remainder can reach WIDTH+1 bits when the divisor uses the MSB.
        rem_sh    = {rem_r, quo_r[WIDTH-1]};
        diff      = {1'b0, rem_sh} - {2'b00, dvs_r};
        ge        = ~diff[WIDTH+1];
        r_step    = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        q_step    = {quo_r[WIDTH-2:0], ge};
        q_fin     = neg_q ? -q_step : q_step;
        r_fin     = neg_r ? -r_step : r_step;
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = INIT;
            INIT: state_nxt = (op_b == '0) ? FIX : ITER;
            ITER: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are written on the edge that enters FIX, so valid and the data coincide.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_a        <= '0;
            op_b        <= '0;
            op_sgn      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= dividend;
                        op_b   <= divisor;
                        op_sgn <= is_signed;
                    end
                end
                INIT: begin
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    quo_r <= a_abs;
                    dvs_r <= b_abs;
                    rem_r <= '0;
                    cnt   <= '0;
                    if (op_b == '0) begin
                        quotient    <= '1;
                        remainder   <= op_a;
                        div_by_zero <= 1'b1;
                    end
                end
                ITER: begin
                    rem_r <= r_step;
                    quo_r <= q_step;
                    cnt   <= cnt + CW'(1);
                    if (last_iter) begin
                        quotient    <= q_fin;
                        remainder   <= r_fin;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign valid = (state == FIX);

endmodule

// File: tb/tb_seq_divider.sv
// Randomised bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic         CLK;
    logic         RST;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;
    logic         valid;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .valid       (valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: SystemVerilog signed division truncates toward zero and
    // the remainder follows the dividend, matching DIV semantics.
    task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
        longint sa, sb, q64, r64;
        if (b == '0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q64 = sa / sb;
            r64 = sa % sb;
            q   = q64[W-1:0];
            r   = r64[W-1:0];
            dbz = 1'b0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after valid.
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input string tag);
        logic [W-1:0] eq, er;
        logic         ed;
        int           lat, bcnt;
        bit           seen;
        ref_div(sgn, a, b, eq, er, ed);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        seen  = 0;
        // lat is the edge number on which the consumer captures valid.
        while (lat < 60) begin
            if (busy) bcnt++;
            if (valid) begin
                seen = 1;
                break;
            end
            if (noise && $urandom_range(0, 1) == 1) begin
                start     = 1'b1;
                dividend  = $urandom;
                divisor   = $urandom;
                is_signed = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
            lat++;
        end
        chk({tag, " valid_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, " latency"}, 64'(lat), (b == '0) ? 64'd2 : 64'(W + 2));
            chk({tag, " busy_cycles"}, 64'(bcnt), 64'(lat));
            chk({tag, " quotient"}, 64'(quotient), 64'(eq));
            chk({tag, " remainder"}, 64'(remainder), 64'(er));
            chk({tag, " dbz"}, 64'(div_by_zero), 64'(ed));
        end
        @(negedge CLK);
        start = 1'b0;
        chk({tag, " valid_pulse"}, 64'(valid), 64'd0);
        chk({tag, " idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        logic [W-1:0] hq, hr;

        RST       = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge CLK);
        chk("rst quotient", 64'(quotient), 64'd0);
        chk("rst remainder", 64'(remainder), 64'd0);
        chk("rst dbz", 64'(div_by_zero), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst valid", 64'(valid), 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        run_op(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0, "divu_big_2");
        run_op(1'b1, 32'd5, 32'd0, 0, "div_5_0");
        run_op(1'b0, 32'd9, 32'd3, 0, "divu_9_3");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_ovf_ops");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "divu_max_max");
        run_op(1'b0, 32'd1234567, 32'd89, 1, "divu_noise");

        // Results stay put while idle.
        hq = quotient;
        hr = remainder;
        repeat (3) @(negedge CLK);
        chk("hold quotient", 64'(quotient), 64'(hq));
        chk("hold remainder", 64'(remainder), 64'(hr));

        // Abort around iteration 10.
        is_signed = 1'b1;
        dividend  = 32'hFFFF_0000;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (11) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("abort quotient", 64'(quotient), 64'd0);
        chk("abort remainder", 64'(remainder), 64'd0);
        chk("abort dbz", 64'(div_by_zero), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort valid", 64'(valid), 64'd0);
        repeat (2) @(negedge CLK);
        chk("abort no_valid", 64'(valid), 64'd0);
        RST = 1'b1;
        @(negedge CLK);
        run_op(1'b1, 32'hFFFF_0000, 32'd3, 0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1;
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            run_op(rs, ra, rb, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
